// File: rtl/pipe_issue_arbiter.sv
// Two-requester round-robin issue arbiter for a fixed-latency pipeline.
// Tracks in-flight ownership with a tag shift register and limits outstanding work per requester.
module pipe_issue_arbiter #(
    parameter int unsigned DW      = 32,
    parameter int unsigned LAT     = 5,
    parameter int unsigned MAX_OUT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_instr,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_instr,
    output logic          req1_ready,
    input  logic          flush,
    output logic [DW-1:0] pipe_instr,
    output logic          pipe_issue,
    input  logic [DW-1:0] pipe_result,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_data,
    output logic          busy
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic [CW-1:0]  cnt0;
    logic [CW-1:0]  cnt1;
    logic           rr;
    logic           pipe_id;
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_id;

    logic ret0;
    logic ret1;
    logic elig0;
    logic elig1;
    logic cand0;
    logic cand1;
    logic gnt0;
    logic gnt1;
    logic accept;

    // Retire decode from the last tag stage; an entry retiring frees a slot this same cycle.
    always_comb begin
        ret0   = tag_v[LAT-1] && !tag_id[LAT-1];
        ret1   = tag_v[LAT-1] &&  tag_id[LAT-1];
        elig0  = (cnt0 < CW'(MAX_OUT)) || ((cnt0 == CW'(MAX_OUT)) && ret0);
        elig1  = (cnt1 < CW'(MAX_OUT)) || ((cnt1 == CW'(MAX_OUT)) && ret1);
        cand0  = req0_valid && elig0 && !flush;
        cand1  = req1_valid && elig1 && !flush;
        gnt0   = cand0 && (!cand1 || !rr);
        gnt1   = cand1 && (!cand0 ||  rr);
        accept = gnt0 || gnt1;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = ret0 && !flush;
    assign rsp1_valid = ret1 && !flush;
    assign rsp_data   = pipe_result;
    assign busy       = (|tag_v) || pipe_issue;

    // Issue register and round-robin pointer; flush leaves rr and pipe_instr alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_issue <= 1'b0;
            pipe_instr <= '0;
            pipe_id    <= 1'b0;
            rr         <= 1'b0;
        end else begin
            pipe_issue <= accept;
            if (accept) begin
                pipe_instr <= gnt1 ? req1_instr : req0_instr;
                pipe_id    <= gnt1;
                rr         <= gnt0;
            end
        end
    end

    // Tag pipe: entry enters on the cycle pipe_issue is high, reaches the last stage LAT cycles later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            tag_v[0]  <= pipe_issue;
            tag_id[0] <= pipe_id;
            if (flush) begin
                tag_v <= '0;
            end
        end
    end

    // Outstanding counters; accept and retire in the same cycle cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (flush) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            case ({gnt0, ret0})
                2'b10:   cnt0 <= cnt0 + CW'(1);
                2'b01:   cnt0 <= cnt0 - CW'(1);
                default: cnt0 <= cnt0;
            endcase
            case ({gnt1, ret1})
                2'b10:   cnt1 <= cnt1 + CW'(1);
                2'b01:   cnt1 <= cnt1 - CW'(1);
                default: cnt1 <= cnt1;
            endcase
        end
    end

endmodule

// File: doc/pipe_issue_arbiter.md
PIPE_ISSUE_ARBITER -- requirements
Module: pipe_issue_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, the instruction/result width.
REQ-002 The block SHALL have parameter LAT, default 5, the cycles from pipe_issue to the matching pipe_result.
REQ-003 The block SHALL have parameter MAX_OUT, default 3, the per-requester in-flight limit (1..LAT).
REQ-004 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have ports req0_valid/req1_valid  in  1  requester N offers an instruction.
REQ-007 The block SHALL have ports req0_instr/req1_instr  in  DW  requester N instruction.
REQ-008 The block SHALL have ports req0_ready/req1_ready  out  1  requester N accepted this cycle (combinational).
REQ-009 The block SHALL have port flush  in  1  discard all in-flight work.
REQ-010 The block SHALL have port pipe_instr  out  DW  registered instruction to the pipeline.
REQ-011 The block SHALL have port pipe_issue  out  1  registered; pipe_instr is valid this cycle.
REQ-012 The block SHALL have port pipe_result  in  DW  pipeline data_out.
REQ-013 The block SHALL have ports rsp0_valid/rsp1_valid  out  1  pipe_result this cycle belongs to requester N.
REQ-014 The block SHALL have port rsp_data  out  DW  combinational copy of pipe_result.
REQ-015 The block SHALL have port busy  out  1  high while any tag-pipe entry is valid or pipe_issue is high.

Function
REQ-016 Transfer: reqN accepted in cycle T iff reqN_valid and reqN_ready in T; at most one accept per cycle.
REQ-017 Eligibility: N is eligible iff cnt_N < MAX_OUT, or cnt_N == MAX_OUT and a response for N retires this cycle.
REQ-018 Grant: one eligible valid requester wins alone; if both, the requester named by the rr pointer wins.
REQ-019 After any accept, rr SHALL point to the non-granted requester; with no accept, rr SHALL hold.
REQ-020 While flush is high, req0_ready and req1_ready SHALL be 0.
REQ-021 An accept in T SHALL drive pipe_issue=1 and pipe_instr=granted instr in T+1; otherwise pipe_issue=0 and pipe_instr holds.
REQ-022 Tag pipe: LAT-entry shift register of {valid,id}, advanced every cycle; the entry entering on pipe_issue carries the granted id.
REQ-023 An entry issued in cycle T SHALL reach the last stage in cycle T+LAT; then rspN_valid=1 for id N, both otherwise 0.
REQ-024 Counters cnt_N (width clog2(MAX_OUT+1)) SHALL increment on accept and decrement on retire; both in the same cycle leave cnt_N unchanged.
REQ-025 Counters SHALL never exceed MAX_OUT or go below 0; REQ-017 guarantees it.
REQ-026 Flush in cycle T SHALL clear all tag valids, cnt0, cnt1 and pipe_issue at T+1; no rsp is raised for pre-flush work, and rsp valids in T itself are forced 0.
REQ-027 Flush SHALL NOT change rr or pipe_instr.
REQ-028 Back-to-back issue SHALL be possible every cycle (full throughput) while eligible requests exist.

Reset
REQ-029 On reset assertion, immediately and asynchronously: pipe_issue=0, pipe_instr=0, tag valids=0, cnt0=cnt1=0, rr=requester 0.
REQ-030 Reset mid-operation SHALL discard in-flight work; rsp valids stay 0 until new issues retire.
REQ-031 First cycle after reset deassertion: both requesters valid -> requester 0 granted.

Verification
REQ-032 Single: req0_valid=1, instr=0x10 in T -> pipe_issue=1, pipe_instr=0x10 at T+1; rsp0_valid=1 at T+1+5, rsp_data=pipe_result.
REQ-033 Contention: both valid continuously from reset -> grants 0,1,0,1...; rsp valids alternate 0,1,0,1 starting 6 cycles after first accept.
REQ-034 Limit: only req0 valid continuously, MAX_OUT=3 -> accepts T,T+1,T+2, ready low until first retire at T+6, accepts again that cycle.
REQ-035 Flush: issue 3 from req1, flush at second issue + 2 -> no rsp1_valid, cnt1=0, req1 accepted the cycle after flush drops.
REQ-036 Reset mid-run: assert reset with 4 in flight -> pipe_issue, all rsp valids 0 immediately and for 5 cycles after release with no requests; busy=0.
REQ-037 Idle: no requests -> pipe_issue=0, pipe_instr unchanged, busy=0, rr unchanged.
